square_motion_ctrl: RTL and testbench
=====================================

Name: square_motion_ctrl

Overview:
- Per-frame position controller for the green player square drawn by the pixel-colour stage.
- Once per frame it samples the direction buttons, steps the square's top-left corner, clamps it to the visible screen, and commits the result atomically.
- Also provides a registered "pixel inside square" flag from the committed position, so the drawing stage never sees a position change mid-frame.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SIZE, 100, square edge length in pixels
- X_INIT, 100, reset X of top-left corner
- Y_INIT, 100, reset Y of top-left corner
- STEP, 4, pixels moved per frame per axis

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  motion enable; frame_tick ignored while low
- frame_tick  in  1  one-cycle pulse per frame, at end of active video
- btn_up  in  1  move -Y
- btn_down  in  1  move +Y
- btn_left  in  1  move -X
- btn_right  in  1  move +X
- x  in  10  current pixel X
- y  in  10  current pixel Y
- x_start  out  10  committed top-left X
- y_start  out  10  committed top-left Y
- pos_valid  out  1  one-cycle pulse when a new position is committed
- busy  out  1  high while an update is in progress
- overrun  out  1  sticky: frame_tick arrived while busy
- in_square  out  1  registered hit flag for (x, y)

Behaviour:
- Reset, synchronous and active-high:
  - x_start=X_INIT, y_start=Y_INIT.
  - pos_valid=0, busy=0, overrun=0, in_square=0.
  - FSM goes to IDLE.
  - Reset mid-update aborts the update; no commit happens.
- FSM states: IDLE, CALC, CLAMP, COMMIT.
- IDLE:
  - If frame_tick && enable at edge N, latch the four buttons and go to CALC.
  - Otherwise stay in IDLE.
- CALC, cycle after edge N:
  - dx = +STEP if right only, -STEP if left only, else 0.
  - dy is formed the same way from down/up.
  - Opposing buttons cancel.
  - Candidates = committed position + delta, computed in 11-bit signed arithmetic.
  - Go to CLAMP.
- CLAMP:
  - Candidate < 0 → 0.
  - X candidate > SCREEN_W-SIZE → SCREEN_W-SIZE.
  - Y candidate > SCREEN_H-SIZE → SCREEN_H-SIZE.
  - Go to COMMIT.
- COMMIT:
  - x_start/y_start take the clamped values on edge N+3.
  - pos_valid is high for exactly the cycle after edge N+3.
  - Go to IDLE.
  - Latency from tick to new position is 3 clocks.
- pos_valid pulses on every commit, even when the position is unchanged (no buttons pressed, or clamped at an edge).
- busy is high in CALC, CLAMP and COMMIT; it is low in IDLE.
- A frame_tick while busy is dropped and sets overrun.
  - overrun clears only on reset.
  - A tick in the same cycle the FSM is in IDLE is accepted normally.
- Button changes after the tick edge have no effect on the current update.
- enable low:
  - Ticks are ignored and overrun is not set.
  - An update already in flight completes.
- in_square:
  - Registered, latency 1.
  - in_square at edge k+1 = (x>=x_start && x<x_start+SIZE && y>=y_start && y<y_start+SIZE), using x/y and the committed position at edge k.
  - Compare in 11 bits so x_start+SIZE cannot wrap.
- Parameter legality: SIZE<=SCREEN_W, SIZE<=SCREEN_H, X_INIT<=SCREEN_W-SIZE, Y_INIT<=SCREEN_H-SIZE.

Decomposition:
- Shared package (game_pkg):
  - screen constants (SCREEN_W, SCREEN_H, coordinate width 10);
  - the FSM state typedef;
  - a signed 11-bit coordinate typedef, reused by future enemy sprites.
- One natural sub-module: rect_hit, a registered point-in-rectangle comparator. It will be reused for enemies and bullets.

Test Plan:
- Reset, then x=150,y=150 → x_start=100, y_start=100, busy=0, overrun=0; one cycle later in_square=1. With x=99 → in_square=0.
- btn_right=1 and one tick → busy high for 3 cycles, pos_valid pulse, x_start=104, y_start=100 exactly 3 clocks after the tick edge.
- Left+right and up together, one tick → x_start unchanged, y_start=96, pos_valid still pulses.
- Position (536,380), right+down held for 5 ticks → clamps and stays at 540,380. Position (2,2) with left+up → 0,0.
- Second tick 1 cycle after the first → only one commit, overrun=1 and it stays high. Reset during CLAMP → position returns to 100,100 with no pos_valid.
- enable=0 with btn_up and a tick → no busy, no pos_valid, position unchanged, overrun=0.

Source files
------------

// File: rtl/square_motion_ctrl_pkg.sv
// rtl/square_motion_ctrl_pkg.sv - shared screen constants, coordinate types and FSM states
package square_motion_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W:0]   coord_s_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CLAMP,
    ST_COMMIT
  } state_e;

  // Opposing buttons cancel to a zero step.
  function automatic coord_s_t axis_delta(input logic neg, input logic pos, input int step);
    coord_s_t d;
    d = '0;
    if (pos && !neg) d = coord_s_t'(step);
    else if (neg && !pos) d = -coord_s_t'(step);
    return d;
  endfunction

  function automatic coord_t clamp_coord(input coord_s_t v, input coord_s_t max_v);
    coord_t r;
    if (v < coord_s_t'(0)) r = '0;
    else if (v > max_v) r = max_v[COORD_W-1:0];
    else r = v[COORD_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/square_motion_ctrl_if.sv
// rtl/square_motion_ctrl_if.sv - control, pixel and position signals of the motion controller
interface square_motion_ctrl_if;
  import square_motion_ctrl_pkg::*;

  logic   enable;
  logic   frame_tick;
  logic   btn_up;
  logic   btn_down;
  logic   btn_left;
  logic   btn_right;
  coord_t x;
  coord_t y;
  coord_t x_start;
  coord_t y_start;
  logic   pos_valid;
  logic   busy;
  logic   overrun;
  logic   in_square;

  modport master (
    output enable, frame_tick, btn_up, btn_down, btn_left, btn_right, x, y,
    input  x_start, y_start, pos_valid, busy, overrun, in_square
  );

  modport slave (
    input  enable, frame_tick, btn_up, btn_down, btn_left, btn_right, x, y,
    output x_start, y_start, pos_valid, busy, overrun, in_square
  );

endinterface

// File: rtl/square_motion_ctrl_rect_hit.sv
// rtl/square_motion_ctrl_rect_hit.sv - registered point-in-rectangle test
// Compared in 11 bits so rx+W cannot wrap; reusable for any sprite box.
module square_motion_ctrl_rect_hit
  import square_motion_ctrl_pkg::*;
#(
  parameter int W = 100,
  parameter int H = 100
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  coord_t px_i,
  input  coord_t py_i,
  input  coord_t rx_i,
  input  coord_t ry_i,
  output logic   hit_o
);

  localparam coord_s_t RW = coord_s_t'(W);
  localparam coord_s_t RH = coord_s_t'(H);

  coord_s_t px, py, rx0, ry0, rx1, ry1;
  logic     hit_d, hit_q;

  assign px  = {1'b0, px_i};
  assign py  = {1'b0, py_i};
  assign rx0 = {1'b0, rx_i};
  assign ry0 = {1'b0, ry_i};
  assign rx1 = rx0 + RW;
  assign ry1 = ry0 + RH;

  assign hit_d = (px >= rx0) && (px < rx1) && (py >= ry0) && (py < ry1);

  always_ff @(posedge clk_i) begin
    if (reset_i) hit_q <= 1'b0;
    else         hit_q <= hit_d;
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// rtl/square_motion_ctrl.sv - per-frame player square position update with clamp and atomic commit
module square_motion_ctrl
  import square_motion_ctrl_pkg::*;
#(
  parameter int SIZE   = 100,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 100,
  parameter int STEP   = 4
) (
  input logic clk_i,
  input logic reset_i,
  square_motion_ctrl_if.slave bus
);

  localparam coord_s_t X_MAX = coord_s_t'(SCREEN_W - SIZE);
  localparam coord_s_t Y_MAX = coord_s_t'(SCREEN_H - SIZE);

  state_e   state_q, state_d;
  logic     up_q, down_q, left_q, right_q;
  coord_s_t cand_x_d, cand_y_d, cand_x_q, cand_y_q;
  coord_t   clamp_x_d, clamp_y_d, clamp_x_q, clamp_y_q;
  coord_t   x_start_q, y_start_q;
  logic     pos_valid_q, overrun_q;
  logic     tick_ok;

  assign tick_ok = bus.frame_tick && bus.enable;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tick_ok) state_d = ST_CALC;
      ST_CALC:   state_d = ST_CLAMP;
      ST_CLAMP:  state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign cand_x_d  = coord_s_t'({1'b0, x_start_q}) + axis_delta(left_q, right_q, STEP);
  assign cand_y_d  = coord_s_t'({1'b0, y_start_q}) + axis_delta(up_q, down_q, STEP);
  assign clamp_x_d = clamp_coord(cand_x_q, X_MAX);
  assign clamp_y_d = clamp_coord(cand_y_q, Y_MAX);

  // Buttons are latched on the accepted tick so later presses cannot disturb this update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      clamp_x_q   <= '0;
      clamp_y_q   <= '0;
      x_start_q   <= coord_t'(X_INIT);
      y_start_q   <= coord_t'(Y_INIT);
      pos_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_valid_q <= (state_q == ST_COMMIT);
      if (tick_ok && state_q != ST_IDLE) overrun_q <= 1'b1;
      if (tick_ok && state_q == ST_IDLE) begin
        up_q    <= bus.btn_up;
        down_q  <= bus.btn_down;
        left_q  <= bus.btn_left;
        right_q <= bus.btn_right;
      end
      if (state_q == ST_CALC) begin
        cand_x_q <= cand_x_d;
        cand_y_q <= cand_y_d;
      end
      if (state_q == ST_CLAMP) begin
        clamp_x_q <= clamp_x_d;
        clamp_y_q <= clamp_y_d;
      end
      if (state_q == ST_COMMIT) begin
        x_start_q <= clamp_x_q;
        y_start_q <= clamp_y_q;
      end
    end
  end

  square_motion_ctrl_rect_hit #(
    .W (SIZE),
    .H (SIZE)
  ) u_hit (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .px_i    (bus.x),
    .py_i    (bus.y),
    .rx_i    (x_start_q),
    .ry_i    (y_start_q),
    .hit_o   (bus.in_square)
  );

  assign bus.x_start   = x_start_q;
  assign bus.y_start   = y_start_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb/tb_square_motion_ctrl.sv - scoreboard bench for square_motion_ctrl
module tb_square_motion_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int x;
    int y;
    int due;
  } exp_t;
  exp_t sb[$];

  square_motion_ctrl_if bus ();
  square_motion_ctrl_if bus2 ();

  square_motion_ctrl dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  square_motion_ctrl #(.X_INIT(2), .Y_INIT(2)) dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Monitor: every committed position must match the oldest expected commit, on time.
  always @(negedge clk) begin
    if (!reset && bus.pos_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pos_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_x", int'(bus.x_start), e.x);
        chk("commit_y", int'(bus.y_start), e.y);
        chk("commit_latency", cyc, e.due);
      end
    end
  end

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    bus.btn_up    = u;
    bus.btn_down  = d;
    bus.btn_left  = l;
    bus.btn_right = r;
  endtask

  // Issue one accepted tick with the current buttons and expect (ex, ey) 3 clocks later.
  task automatic frame(input int ex, input int ey);
    exp_t e;
    e.x = ex;
    e.y = ey;
    e.due = cyc + 4;
    sb.push_back(e);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    set_btn(1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_calc", int'(bus.busy), 1);
    @(negedge clk);
    chk("busy_clamp", int'(bus.busy), 1);
    @(negedge clk);
    chk("busy_commit", int'(bus.busy), 1);
    @(negedge clk);
    chk("busy_idle", int'(bus.busy), 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hit(input int px, input int py, input int exp);
    bus.x = 10'(px);
    bus.y = 10'(py);
    @(negedge clk);
    chk("in_square", int'(bus.in_square), exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.frame_tick = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    bus.x = 10'd150;
    bus.y = 10'd150;
    bus2.enable = 1'b1;
    bus2.frame_tick = 1'b0;
    bus2.btn_up = 1'b0;
    bus2.btn_down = 1'b0;
    bus2.btn_left = 1'b0;
    bus2.btn_right = 1'b0;
    bus2.x = '0;
    bus2.y = '0;
    repeat (3) @(negedge clk);

    chk("rst_x_start", int'(bus.x_start), 100);
    chk("rst_y_start", int'(bus.y_start), 100);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_pos_valid", int'(bus.pos_valid), 0);
    chk("rst_in_square", int'(bus.in_square), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_square_150", int'(bus.in_square), 1);
    hit(99, 150, 0);

    // Clamp at the low corner on the second instance: (2,2) - 4 -> (0,0).
    chk("dut2_rst_x", int'(bus2.x_start), 2);
    bus2.btn_left = 1'b1;
    bus2.btn_up = 1'b1;
    bus2.frame_tick = 1'b1;
    @(negedge clk);
    bus2.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("dut2_pos_valid", int'(bus2.pos_valid), 1);
    chk("dut2_clamp_x", int'(bus2.x_start), 0);
    chk("dut2_clamp_y", int'(bus2.y_start), 0);
    bus2.btn_left = 1'b0;
    bus2.btn_up = 1'b0;

    set_btn(1'b0, 1'b0, 1'b0, 1'b1);
    frame(104, 100);
    hit(103, 150, 0);
    hit(104, 150, 1);
    hit(203, 150, 1);
    hit(204, 150, 0);
    hit(150, 99, 0);
    hit(150, 199, 1);
    hit(150, 200, 0);

    set_btn(1'b1, 1'b0, 1'b1, 1'b1);
    frame(104, 96);

    for (int i = 1; i <= 71; i++) begin
      set_btn(1'b0, 1'b1, 1'b0, 1'b1);
      frame(104 + 4 * i, 96 + 4 * i);
    end
    for (int i = 1; i <= 37; i++) begin
      set_btn(1'b0, 1'b0, 1'b0, 1'b1);
      frame(388 + 4 * i, 380);
    end
    chk("pos_536_x", int'(bus.x_start), 536);
    for (int i = 0; i < 5; i++) begin
      set_btn(1'b0, 1'b1, 1'b0, 1'b1);
      frame(540, 380);
    end

    // A second tick one cycle after the first is dropped and flags overrun.
    begin
      exp_t e;
      e.x = 536;
      e.y = 380;
      e.due = cyc + 4;
      sb.push_back(e);
      set_btn(1'b0, 1'b0, 1'b1, 1'b0);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      set_btn(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      bus.frame_tick = 1'b0;
      chk("overrun_set", int'(bus.overrun), 1);
      repeat (6) @(negedge clk);
      chk("overrun_sticky", int'(bus.overrun), 1);
      chk("overrun_x", int'(bus.x_start), 536);
    end

    // Reset while in CLAMP aborts the update.
    set_btn(1'b0, 1'b0, 1'b1, 1'b0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("busy_before_abort", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_x", int'(bus.x_start), 100);
    chk("abort_y", int'(bus.y_start), 100);
    chk("abort_overrun", int'(bus.overrun), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_pos_valid", int'(bus.pos_valid), 0);
      chk("abort_busy", int'(bus.busy), 0);
    end
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);

    // Ticks with enable low are ignored entirely.
    bus.enable = 1'b0;
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dis_busy", int'(bus.busy), 0);
      chk("dis_pos_valid", int'(bus.pos_valid), 0);
      @(negedge clk);
    end
    chk("dis_x", int'(bus.x_start), 100);
    chk("dis_y", int'(bus.y_start), 100);
    chk("dis_overrun", int'(bus.overrun), 0);
    bus.enable = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
